// File: rtl/calc_pkg.sv
// Shared opcode and FSM state encodings for the stream calculator family.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_EQL = 2'd2,
        OP_CLR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_HAVE_ACC  = 2'd1,
        S_WAIT_OPND = 2'd2,
        S_RESULT    = 2'd3
    } state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational unsigned add/subtract with carry/borrow detection and optional clamping.
module calc_alu
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

    localparam int unsigned XW = WIDTH + 1;

    logic [XW-1:0] sum_c;
    logic [XW-1:0] diff_c;

    // One extra bit holds the carry (add) or borrow (sub).
    always_comb begin
        sum_c  = XW'(a) + XW'(b);
        diff_c = XW'(a) - XW'(b);
        y      = a;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                ovf = sum_c[WIDTH];
                y   = (SATURATE && sum_c[WIDTH]) ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];
            end
            OP_SUB: begin
                ovf = diff_c[WIDTH];
                y   = (SATURATE && diff_c[WIDTH]) ? {WIDTH{1'b0}} : diff_c[WIDTH-1:0];
            end
            default: begin
                y   = a;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/stream_calculator.sv
// Token-stream accumulate/add/subtract calculator with valid/ready on both sides.
module stream_calculator
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b0,
    parameter bit          CHAIN    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_is_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    op_e              pend_op_q, pend_op_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    op_e              tok_op_c;
    logic [WIDTH-1:0] alu_y_c;
    logic             alu_ovf_c;

    assign tok_op_c = op_e'(in_data[1:0]);

    calc_alu #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_alu (
        .a   (acc_q),
        .b   (in_data),
        .op  (pend_op_q),
        .y   (alu_y_c),
        .ovf (alu_ovf_c)
    );

    // Ready is decoded straight from the state register; only a pending result stalls input.
    assign in_ready     = (state_q != S_RESULT);
    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;
    assign out_valid    = out_valid_q;
    assign err          = err_q;

    // Next-state and register updates; in_valid implies acceptance outside S_RESULT.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        pend_op_d   = pend_op_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!in_is_op) begin
                        acc_d   = in_data;
                        ovf_d   = 1'b0;
                        state_d = S_HAVE_ACC;
                    end else if (tok_op_c != OP_CLR) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_HAVE_ACC: begin
                if (in_valid) begin
                    if (!in_is_op) begin
                        err_d = 1'b1;
                    end else begin
                        case (tok_op_c)
                            OP_ADD, OP_SUB: begin
                                pend_op_d = tok_op_c;
                                state_d   = S_WAIT_OPND;
                            end
                            OP_EQL: begin
                                out_data_d  = acc_q;
                                out_ovf_d   = ovf_q;
                                out_valid_d = 1'b1;
                                state_d     = S_RESULT;
                            end
                            default: begin
                                acc_d   = '0;
                                ovf_d   = 1'b0;
                                state_d = S_IDLE;
                            end
                        endcase
                    end
                end
            end
            S_WAIT_OPND: begin
                if (in_valid) begin
                    if (!in_is_op) begin
                        acc_d   = alu_y_c;
                        ovf_d   = ovf_q | alu_ovf_c;
                        state_d = S_HAVE_ACC;
                    end else begin
                        case (tok_op_c)
                            OP_ADD, OP_SUB: pend_op_d = tok_op_c;
                            OP_EQL:         err_d     = 1'b1;
                            default: begin
                                acc_d   = '0;
                                ovf_d   = 1'b0;
                                state_d = S_IDLE;
                            end
                        endcase
                    end
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    if (CHAIN) begin
                        state_d = S_HAVE_ACC;
                    end else begin
                        acc_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            pend_op_q   <= OP_ADD;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            pend_op_q   <= pend_op_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_stream_calculator.sv
// Bench: two calculators (wrap/no-chain and saturate/chain) against a token-level reference model.
module tb_stream_calculator;

    localparam int unsigned W    = 8;
    localparam int          MAXV = (1 << W) - 1;
    localparam int          ADD  = 0;
    localparam int          SUB  = 1;
    localparam int          EQL  = 2;
    localparam int          CLR  = 3;

    // Model phases: waiting for first number, holding a value, waiting for operand, result pending.
    localparam int PH_EMPTY = 0;
    localparam int PH_VALUE = 1;
    localparam int PH_OPND  = 2;
    localparam int PH_OUT   = 3;

    logic         clk = 1'b0;
    logic         reset        [2];
    logic [W-1:0] in_data      [2];
    logic         in_is_op     [2];
    logic         in_valid     [2];
    logic         in_ready     [2];
    logic [W-1:0] out_data     [2];
    logic         out_overflow [2];
    logic         out_valid    [2];
    logic         out_ready    [2];
    logic         err          [2];

    always #5 clk = ~clk;

    stream_calculator #(.WIDTH(W), .SATURATE(1'b0), .CHAIN(1'b0)) dut0 (
        .clk(clk), .reset(reset[0]), .in_data(in_data[0]), .in_is_op(in_is_op[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_data(out_data[0]),
        .out_overflow(out_overflow[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .err(err[0])
    );

    stream_calculator #(.WIDTH(W), .SATURATE(1'b1), .CHAIN(1'b1)) dut1 (
        .clk(clk), .reset(reset[1]), .in_data(in_data[1]), .in_is_op(in_is_op[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_data(out_data[1]),
        .out_overflow(out_overflow[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .err(err[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit m_sat   [2] = '{1'b0, 1'b1};
    bit m_chain [2] = '{1'b0, 1'b1};
    int m_phase [2];
    int m_acc   [2];
    int m_pop   [2];
    int m_ovf   [2];
    int m_out   [2];
    int m_oovf  [2];
    int m_err   [2];

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    function automatic void model_reset(int k);
        m_phase[k] = PH_EMPTY;
        m_acc[k]   = 0;
        m_pop[k]   = ADD;
        m_ovf[k]   = 0;
        m_out[k]   = 0;
        m_oovf[k]  = 0;
        m_err[k]   = 0;
    endfunction

    // Apply one cycle of stimulus to the reference model of instance k.
    function automatic void model_step(int k, bit v, bit isop, int d, bit ordy);
        int op;
        int r;
        bit o;
        op       = d % 4;
        m_err[k] = 0;
        if (m_phase[k] == PH_OUT) begin
            if (ordy) begin
                m_ovf[k] = 0;
                if (m_chain[k]) m_phase[k] = PH_VALUE;
                else begin
                    m_phase[k] = PH_EMPTY;
                    m_acc[k]   = 0;
                end
            end
        end else if (v) begin
            case (m_phase[k])
                PH_EMPTY: begin
                    if (!isop) begin
                        m_acc[k]   = d;
                        m_ovf[k]   = 0;
                        m_phase[k] = PH_VALUE;
                    end else if (op != CLR) m_err[k] = 1;
                end
                PH_VALUE: begin
                    if (!isop) m_err[k] = 1;
                    else if (op == ADD || op == SUB) begin
                        m_pop[k]   = op;
                        m_phase[k] = PH_OPND;
                    end else if (op == EQL) begin
                        m_out[k]   = m_acc[k];
                        m_oovf[k]  = m_ovf[k];
                        m_phase[k] = PH_OUT;
                    end else begin
                        m_acc[k]   = 0;
                        m_ovf[k]   = 0;
                        m_phase[k] = PH_EMPTY;
                    end
                end
                default: begin
                    if (!isop) begin
                        if (m_pop[k] == ADD) begin
                            r = m_acc[k] + d;
                            o = (r > MAXV);
                            if (o) r = m_sat[k] ? MAXV : r - (MAXV + 1);
                        end else begin
                            o = (d > m_acc[k]);
                            r = o ? (m_sat[k] ? 0 : m_acc[k] - d + MAXV + 1) : m_acc[k] - d;
                        end
                        m_acc[k]   = r;
                        m_ovf[k]   = m_ovf[k] | int'(o);
                        m_phase[k] = PH_VALUE;
                    end else if (op == ADD || op == SUB) m_pop[k] = op;
                    else if (op == EQL) m_err[k] = 1;
                    else begin
                        m_acc[k]   = 0;
                        m_ovf[k]   = 0;
                        m_phase[k] = PH_EMPTY;
                    end
                end
            endcase
        end
    endfunction

    task automatic check_all(string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, " in_ready"},  k, 32'(in_ready[k]),     32'(m_phase[k] != PH_OUT));
            chk({tag, " out_valid"}, k, 32'(out_valid[k]),    32'(m_phase[k] == PH_OUT));
            chk({tag, " err"},       k, 32'(err[k]),          32'(m_err[k]));
            chk({tag, " out_data"},  k, 32'(out_data[k]),     32'(m_out[k]));
            chk({tag, " out_ovf"},   k, 32'(out_overflow[k]), 32'(m_oovf[k]));
        end
    endtask

    // Drive instance idx for one cycle (the other idles with out_ready=1), then check both.
    task automatic step(int idx, bit r, bit v, bit isop, int d, bit ordy, string tag);
        for (int k = 0; k < 2; k++) begin
            if (k == idx) begin
                reset[k]     = r;
                in_valid[k]  = v;
                in_is_op[k]  = isop;
                in_data[k]   = W'(d);
                out_ready[k] = ordy;
            end else begin
                reset[k]     = 1'b0;
                in_valid[k]  = 1'b0;
                in_is_op[k]  = 1'b0;
                in_data[k]   = '0;
                out_ready[k] = 1'b1;
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (k == idx && r) model_reset(k);
            else if (k == idx) model_step(k, v, isop, d, ordy);
            else model_step(k, 1'b0, 1'b0, 0, 1'b1);
        end
        #1;
        check_all(tag);
    endtask

    task automatic num(int idx, int d);
        step(idx, 1'b0, 1'b1, 1'b0, d, 1'b1, "num");
    endtask

    task automatic opc(int idx, int o);
        step(idx, 1'b0, 1'b1, 1'b1, o, 1'b1, "opc");
    endtask

    task automatic idle(int idx);
        step(idx, 1'b0, 1'b0, 1'b0, 0, 1'b1, "idle");
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k]     = 1'b1;
            in_valid[k]  = 1'b0;
            in_is_op[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        model_reset(0);
        model_reset(1);
        #1;
        check_all("reset");

        // 5 + 7 = 12, result visible for exactly one cycle with out_ready high
        num(0, 5); opc(0, ADD); num(0, 7); opc(0, EQL);
        chk("t1 data", 0, 32'(out_data[0]), 32'd12);
        chk("t1 ovf",  0, 32'(out_overflow[0]), 32'd0);
        idle(0);

        // 250 + 10 overflow: wrap vs saturate
        for (int k = 0; k < 2; k++) begin
            opc(k, CLR); num(k, 250); opc(k, ADD); num(k, 10); opc(k, EQL);
            chk("t2 data", k, 32'(out_data[k]), (k == 1) ? 32'd255 : 32'd4);
            chk("t2 ovf",  k, 32'(out_overflow[k]), 32'd1);
            idle(k);
        end

        // 3 - 5 underflow: wrap vs clamp to 0
        for (int k = 0; k < 2; k++) begin
            opc(k, CLR); num(k, 3); opc(k, SUB); num(k, 5); opc(k, EQL);
            chk("t3 data", k, 32'(out_data[k]), (k == 1) ? 32'd0 : 32'd254);
            chk("t3 ovf",  k, 32'(out_overflow[k]), 32'd1);
            idle(k);
        end

        // Backpressure hold, then chaining the held result
        opc(1, CLR); num(1, 12); step(1, 1'b0, 1'b1, 1'b1, EQL, 1'b0, "t4 eql");
        for (int i = 0; i < 3; i++) begin
            step(1, 1'b0, 1'b1, 1'b0, 99, 1'b0, "t4 hold");
            chk("t4 hold data", 1, 32'(out_data[1]), 32'd12);
            chk("t4 hold rdy",  1, 32'(in_ready[1]), 32'd0);
        end
        idle(1);
        opc(1, ADD); num(1, 1); opc(1, EQL);
        chk("t4 chain", 1, 32'(out_data[1]), 32'd13);
        idle(1);

        // Illegal opcode in idle, opcode replacement, clear mid-expression
        opc(0, ADD);
        chk("t5 err", 0, 32'(err[0]), 32'd1);
        idle(0);
        num(0, 9); opc(0, ADD); opc(0, ADD); opc(0, SUB); num(0, 2); opc(0, EQL);
        chk("t5 repl", 0, 32'(out_data[0]), 32'd7);
        idle(0);
        num(0, 9); opc(0, ADD); opc(0, CLR); num(0, 4); opc(0, EQL);
        chk("t5 clr", 0, 32'(out_data[0]), 32'd4);
        idle(0);

        // Boundaries: max + 0 and 0 - 0 without overflow
        num(0, MAXV); opc(0, ADD); num(0, 0); opc(0, EQL);
        chk("bnd add", 0, 32'(out_overflow[0]), 32'd0);
        idle(0);
        num(0, 0); opc(0, SUB); num(0, 0); opc(0, EQL);
        chk("bnd sub", 0, 32'(out_data[0]), 32'd0);
        idle(0);

        // Reset mid-expression
        num(0, 6); opc(0, ADD);
        step(0, 1'b1, 1'b1, 1'b0, 77, 1'b1, "t6 reset");
        chk("t6 in_ready", 0, 32'(in_ready[0]), 32'd1);
        num(0, 8); opc(0, EQL);
        chk("t6 data", 0, 32'(out_data[0]), 32'd8);
        idle(0);

        // Random token streams with random backpressure and occasional reset
        for (int i = 0; i < 3000; i++) begin
            int idx;
            bit r;
            bit v;
            bit isop;
            int d;
            int sel;
            idx  = int'($urandom_range(0, 1));
            r    = ($urandom_range(0, 99) == 0);
            v    = ($urandom_range(0, 3) != 0);
            isop = ($urandom_range(0, 1) == 1);
            sel  = int'($urandom_range(0, 4));
            if (isop) d = int'($urandom_range(0, 3));
            else if (sel == 0) d = 0;
            else if (sel == 1) d = MAXV;
            else if (sel == 2) d = 1;
            else d = int'($urandom_range(0, MAXV));
            step(idx, r, v, isop, d, ($urandom_range(0, 2) != 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
